// File: rtl/framebuffer_reader_pkg.sv
// rtl/framebuffer_reader_pkg.sv - shared constants and helpers for the framebuffer reader
package framebuffer_reader_pkg;

    // Field positions inside a packed {R,G,B} framebuffer word.
    localparam int NUM_CH = 3;
    localparam int CH_R   = 2;
    localparam int CH_G   = 1;
    localparam int CH_B   = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int fb_w(input int h_res, input int scale);
        return h_res / scale;
    endfunction

    function automatic int fb_h(input int v_res, input int scale);
        return v_res / scale;
    endfunction

endpackage

// File: rtl/framebuffer_reader_if.sv
// rtl/framebuffer_reader_if.sv - read port between the framebuffer reader and its block RAM
interface framebuffer_reader_if
    import framebuffer_reader_pkg::*;
#(
    parameter int ADDRW = 17,
    parameter int DATAW = NUM_CH * 4
);
    logic             fb_rd;
    logic [ADDRW-1:0] fb_addr;
    logic [DATAW-1:0] fb_data;

    modport master (output fb_rd, output fb_addr, input fb_data);
    modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/framebuffer_reader_sig_delay.sv
// rtl/framebuffer_reader_sig_delay.sv - fixed-depth shift-register delay with a reset value
module framebuffer_reader_sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/framebuffer_reader.sv
// rtl/framebuffer_reader.sv - scaled framebuffer pixel source with sync delay matched to RAM latency
module framebuffer_reader
    import framebuffer_reader_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int SCALE     = 2,
    parameter int COLR_BITS = 4,
    parameter int FB_ADDRW  = 17,
    parameter int MEM_LAT   = 1,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0
) (
    input  logic                 i_pixclk,
    input  logic                 i_rst,
    input  logic                 i_hs,
    input  logic                 i_vs,
    input  logic                 i_de,
    input  logic                 i_frame,
    framebuffer_reader_if.master fb,
    output logic                 o_hs,
    output logic                 o_vs,
    output logic                 o_de,
    output logic [COLR_BITS-1:0] o_r,
    output logic [COLR_BITS-1:0] o_g,
    output logic [COLR_BITS-1:0] o_b
);
    localparam int FB_W    = fb_w(H_RES, SCALE);
    localparam int FB_SIZE = FB_W * fb_h(V_RES, SCALE);
    localparam int SUB_W   = (SCALE > 1) ? clog2(SCALE) : 1;

    localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(SCALE - 1);
    localparam logic [FB_ADDRW:0] LINE_STEP = (FB_ADDRW+1)'(FB_W);
    localparam logic [FB_ADDRW:0] FB_END    = (FB_ADDRW+1)'(FB_SIZE);
    localparam logic [3:0]        DLY_RST   = {~H_POL, ~V_POL, 1'b0, 1'b0};

    logic                sync_ok;
    logic                sync_now;
    logic                de_q;
    logic [FB_ADDRW-1:0] line_base;
    logic [FB_ADDRW-1:0] col_addr;
    logic [SUB_W-1:0]    col_sub;
    logic [SUB_W-1:0]    row_sub;
    logic [FB_ADDRW:0]   next_base;

    // A frame pulse arms the reader in its own cycle so a coincident de cycle reads address 0.
    assign sync_now  = sync_ok | i_frame;
    assign next_base = {1'b0, line_base} + LINE_STEP;

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            sync_ok    <= 1'b0;
            de_q       <= 1'b0;
            line_base  <= '0;
            col_addr   <= '0;
            col_sub    <= '0;
            row_sub    <= '0;
            fb.fb_rd   <= 1'b0;
            fb.fb_addr <= '0;
        end else begin
            de_q     <= i_de;
            fb.fb_rd <= i_de & sync_now;
            if (i_frame) begin
                sync_ok    <= 1'b1;
                line_base  <= '0;
                col_addr   <= '0;
                col_sub    <= '0;
                row_sub    <= '0;
                fb.fb_addr <= '0;
            end else if (sync_ok) begin
                fb.fb_addr <= line_base + col_addr;
                if (i_de) begin
                    if (col_sub == SUB_MAX) begin
                        col_sub  <= '0;
                        col_addr <= col_addr + 1'b1;
                    end else begin
                        col_sub <= col_sub + 1'b1;
                    end
                end else if (de_q) begin
                    col_addr <= '0;
                    col_sub  <= '0;
                    if (row_sub == SUB_MAX) begin
                        row_sub   <= '0;
                        // An over-long frame restarts at the top rather than reading past the buffer.
                        line_base <= (next_base >= FB_END) ? '0 : next_base[FB_ADDRW-1:0];
                    end else begin
                        row_sub <= row_sub + 1'b1;
                    end
                end
            end
        end
    end

    logic hs_d, vs_d, de_d, ok_d;

    framebuffer_reader_sig_delay #(
        .WIDTH   (4),
        .DEPTH   (MEM_LAT + 1),
        .RST_VAL (DLY_RST)
    ) u_sync_delay (
        .clk  (i_pixclk),
        .rst  (i_rst),
        .din  ({i_hs, i_vs, i_de, sync_now}),
        .dout ({hs_d, vs_d, de_d, ok_d})
    );

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            o_hs <= ~H_POL;
            o_vs <= ~V_POL;
            o_de <= 1'b0;
            o_r  <= '0;
            o_g  <= '0;
            o_b  <= '0;
        end else begin
            o_hs <= hs_d;
            o_vs <= vs_d;
            o_de <= de_d;
            if (de_d && ok_d) begin
                o_r <= fb.fb_data[CH_R*COLR_BITS +: COLR_BITS];
                o_g <= fb.fb_data[CH_G*COLR_BITS +: COLR_BITS];
                o_b <= fb.fb_data[CH_B*COLR_BITS +: COLR_BITS];
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_reader.sv
// tb/tb_framebuffer_reader.sv - two framebuffer_reader configurations against a line/column reference model
module tb_framebuffer_reader;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hs = 1'b1, vs = 1'b1, de = 1'b0, frame = 1'b0;

    always #5 clk = ~clk;

    framebuffer_reader_if #(.ADDRW(17), .DATAW(12)) fb_a ();
    framebuffer_reader_if #(.ADDRW(7),  .DATAW(12)) fb_b ();

    logic       o_hs_a, o_vs_a, o_de_a, o_hs_b, o_vs_b, o_de_b;
    logic [3:0] o_r_a, o_g_a, o_b_a, o_r_b, o_g_b, o_b_b;

    framebuffer_reader dut_a (
        .i_pixclk (clk), .i_rst (rst), .i_hs (hs), .i_vs (vs), .i_de (de), .i_frame (frame),
        .fb (fb_a),
        .o_hs (o_hs_a), .o_vs (o_vs_a), .o_de (o_de_a), .o_r (o_r_a), .o_g (o_g_a), .o_b (o_b_a)
    );

    framebuffer_reader #(
        .H_RES (16), .V_RES (8), .SCALE (1), .COLR_BITS (4), .FB_ADDRW (7),
        .MEM_LAT (2), .H_POL (1'b1), .V_POL (1'b1)
    ) dut_b (
        .i_pixclk (clk), .i_rst (rst), .i_hs (hs), .i_vs (vs), .i_de (de), .i_frame (frame),
        .fb (fb_b),
        .o_hs (o_hs_b), .o_vs (o_vs_b), .o_de (o_de_b), .o_r (o_r_b), .o_g (o_g_b), .o_b (o_b_b)
    );

    // Block RAM models: stored word equals address[11:0].
    logic [11:0] ram_b_q1;
    always @(posedge clk) fb_a.fb_data <= 12'(fb_a.fb_addr);
    always @(posedge clk) begin
        ram_b_q1     <= 12'(fb_b.fb_addr);
        fb_b.fb_data <= ram_b_q1;
    end

    function automatic int p_s(input int k);   return (k == 0) ? 2 : 1;     endfunction
    function automatic int p_lat(input int k); return (k == 0) ? 1 : 2;     endfunction
    function automatic int p_fbw(input int k); return (k == 0) ? 320 : 16;  endfunction
    function automatic int p_fbh(input int k); return (k == 0) ? 240 : 8;   endfunction
    function automatic int p_aw(input int k);  return (k == 0) ? 17 : 7;    endfunction
    function automatic bit p_hp(input int k);  return (k == 0) ? 1'b0 : 1'b1; endfunction
    function automatic bit p_vp(input int k);  return (k == 0) ? 1'b0 : 1'b1; endfunction

    int   total = 0;
    int   bad   = 0;
    bit   m_sync [2];
    bit   m_pde  [2];
    int   m_line [2];
    int   m_col  [2];
    bit   e_rd   [2];
    int   e_addr [2];
    bit   e_achk [2];
    out_t pipe   [2][4];

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    // Reference: address = stored-row * FB_W + column/SCALE, stored-row = (line/SCALE) mod FB_H.
    task automatic model_step(input int k, input bit r, input bit h, input bit v, input bit d, input bit f);
        int a;
        int dep;
        dep = p_lat(k) + 2;
        if (r) begin
            m_sync[k] = 1'b0; m_pde[k] = 1'b0; m_line[k] = 0; m_col[k] = 0;
            e_rd[k] = 1'b0; e_addr[k] = 0; e_achk[k] = 1'b1;
            for (int i = 0; i < 4; i++) pipe[k][i] = {~p_hp(k), ~p_vp(k), 1'b0, 12'd0};
            return;
        end
        if (f) begin
            m_sync[k] = 1'b1; m_line[k] = 0; m_col[k] = 0;
        end
        a = 0;
        if (m_sync[k])
            a = (((m_line[k] / p_s(k)) % p_fbh(k)) * p_fbw(k) + m_col[k] / p_s(k)) % (1 << p_aw(k));
        e_rd[k]   = d && m_sync[k];
        e_addr[k] = a;
        e_achk[k] = !m_sync[k] || e_rd[k];
        if (!f && m_sync[k]) begin
            if (d) m_col[k]++;
            else if (m_pde[k]) begin
                m_line[k]++;
                m_col[k] = 0;
            end
        end
        m_pde[k] = d;
        for (int i = dep - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        pipe[k][0] = {h, v, d, (d && m_sync[k]) ? 12'(a) : 12'd0};
    endtask

    task automatic check_outputs(input int k);
        out_t exp_o;
        out_t obs;
        logic rd;
        int   addr;
        exp_o = pipe[k][p_lat(k) + 1];
        if (k == 0) begin
            rd = fb_a.fb_rd; addr = int'(fb_a.fb_addr);
            obs = {o_hs_a, o_vs_a, o_de_a, o_r_a, o_g_a, o_b_a};
        end else begin
            rd = fb_b.fb_rd; addr = int'(fb_b.fb_addr);
            obs = {o_hs_b, o_vs_b, o_de_b, o_r_b, o_g_b, o_b_b};
        end
        chk(k, "fb_rd", 32'(rd), 32'(e_rd[k]));
        if (e_achk[k]) chk(k, "fb_addr", addr, e_addr[k]);
        chk(k, "hs_vs", 32'({obs.hs, obs.vs}), 32'({exp_o.hs, exp_o.vs}));
        chk(k, "de", 32'(obs.de), 32'(exp_o.de));
        chk(k, "rgb", 32'(obs.rgb), 32'(exp_o.rgb));
    endtask

    task automatic tick(input bit r, input bit h, input bit v, input bit d, input bit f);
        rst = r; hs = h; vs = v; de = d; frame = f;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, h, v, d, f);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    task automatic run_line(input int len);
        for (int i = 0; i < 4; i++)   tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)   tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)   tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic start_frame();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit cur_de;
        int run;
        cur_de = 1'b0;
        run    = 0;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk(0, "rst_hs_a", 32'(o_hs_a), 32'd1);
        chk(1, "rst_hs_b", 32'(o_hs_b), 32'd0);
        chk(1, "rst_vs_b", 32'(o_vs_b), 32'd0);

        // No frame pulse yet: lines must stay blank with no reads.
        run_line(20);

        start_frame();
        for (int l = 0; l < 4; l++) run_line(640);

        // Reset in the middle of a line, then blank until the next frame.
        for (int i = 0; i < 200; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_line(640);
        start_frame();
        for (int l = 0; l < 2; l++) run_line(640);

        // Frame pulse landing on an active pixel restarts addressing at 0.
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk(0, "frame_in_de_addr", 32'(fb_a.fb_addr), 32'd0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_line(640);

        for (int n = 0; n < 4000; n++) begin
            if (run == 0) begin
                cur_de = ~cur_de;
                run    = int'($urandom_range(1, 40));
            end
            run--;
            tick(($urandom % 1500) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 cur_de, ($urandom % 1200) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
